// File: rtl/multicycle_adder_pkg.sv
// Shared definitions for the multi-cycle add/subtract unit: FSM encodings and
// the counter-width helper.
package multicycle_adder_pkg;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   // Bits needed to index n chunks, never less than one.
   function automatic int cnt_width(input int n);
      int w;
      w = 1;
      while ((1 << w) < n) w++;
      return w;
   endfunction

endpackage

// File: rtl/multicycle_adder_if.sv
// Request/result bundle of the multi-cycle adder. Handshake: start is only
// accepted while busy is low; done pulses for one cycle when r/ovf are updated.
interface multicycle_adder_if #(
   parameter int WIDTH = 8
);
   logic             start;
   logic             op_sub;
   logic             cin;
   logic [WIDTH-1:0] x;
   logic [WIDTH-1:0] y;
   logic             busy;
   logic             done;
   logic [WIDTH:0]   r;
   logic             ovf;

   modport master (output start, op_sub, cin, x, y, input busy, done, r, ovf);
   modport slave  (input start, op_sub, cin, x, y, output busy, done, r, ovf);
endinterface

// File: rtl/multicycle_adder_chunk_adder.sv
// Combinational CHUNK-bit adder; every carry is formed directly from the
// generate/propagate terms and the carry-in (lookahead, no ripple).
module chunk_adder #(
   parameter int CHUNK = 2
) (
   input  logic [CHUNK-1:0] a_i,
   input  logic [CHUNK-1:0] b_i,
   input  logic             ci_i,
   output logic [CHUNK-1:0] s_o,
   output logic             co_o
);
   logic [CHUNK-1:0] g;
   logic [CHUNK-1:0] p;
   logic [CHUNK:0]   c;
   logic             term;

   assign g = a_i & b_i;
   assign p = a_i ^ b_i;

   // c[i+1] = OR_j (g[j] & p[j+1..i])  |  (p[0..i] & ci)
   always_comb begin
      c    = '0;
      term = 1'b0;
      c[0] = ci_i;
      for (int i = 0; i < CHUNK; i++) begin
         term = ci_i;
         for (int j = 0; j <= i; j++) term = term & p[j];
         c[i+1] = term;
         for (int j = 0; j <= i; j++) begin
            term = g[j];
            for (int k = j + 1; k <= i; k++) term = term & p[k];
            c[i+1] = c[i+1] | term;
         end
      end
   end

   assign s_o  = p ^ c[CHUNK-1:0];
   assign co_o = c[CHUNK];
endmodule

// File: rtl/multicycle_adder.sv
// Multi-cycle WIDTH-bit add/subtract: one CHUNK-bit slice per clock through a
// single chunk_adder, result and signed overflow published with a done pulse.
module multicycle_adder
   import multicycle_adder_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int CHUNK = 2
) (
   input  logic                clk,
   input  logic                rst,
   multicycle_adder_if.slave   bus,
   output logic [1:0]          state_o
);
   localparam int NCHUNK = WIDTH / CHUNK;
   localparam int CNT_W  = cnt_width(NCHUNK);
   localparam logic [CNT_W-1:0] LAST       = CNT_W'(NCHUNK - 1);
   localparam logic [WIDTH-1:0] CHUNK_MASK = WIDTH'({CHUNK{1'b1}});

   logic [1:0]       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] xa_q, xa_d;
   logic [WIDTH-1:0] yb_q, yb_d;
   logic             carry_q, carry_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic [WIDTH:0]   r_q, r_d;
   logic             ovf_q, ovf_d;
   logic             done_q;

   logic [31:0]      sh;
   logic [CHUNK-1:0] ca, cb, cs;
   logic             cco;

   assign sh = 32'(cnt_q) * CHUNK;
   assign ca = CHUNK'(xa_q >> sh);
   assign cb = CHUNK'(yb_q >> sh);

   chunk_adder #(.CHUNK(CHUNK)) u_chunk (
      .a_i (ca),
      .b_i (cb),
      .ci_i(carry_q),
      .s_o (cs),
      .co_o(cco)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      xa_d    = xa_q;
      yb_d    = yb_q;
      carry_d = carry_q;
      sum_d   = sum_q;
      r_d     = r_q;
      ovf_d   = ovf_q;
      case (state_q)
         S_IDLE: if (bus.start) begin
            xa_d    = bus.x;
            yb_d    = bus.op_sub ? ~bus.y : bus.y;
            carry_d = bus.op_sub ? 1'b1 : bus.cin;
            cnt_d   = '0;
            state_d = S_RUN;
         end
         S_RUN: begin
            sum_d   = (sum_q & ~(CHUNK_MASK << sh)) | (WIDTH'(cs) << sh);
            carry_d = cco;
            cnt_d   = cnt_q + 1'b1;
            // r/ovf only change on the last slice, so partial sums never show.
            if (cnt_q == LAST) begin
               r_d     = {cco, sum_d};
               ovf_d   = (xa_q[WIDTH-1] == yb_q[WIDTH-1]) && (sum_d[WIDTH-1] != xa_q[WIDTH-1]);
               state_d = S_DONE;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         xa_q    <= '0;
         yb_q    <= '0;
         carry_q <= 1'b0;
         sum_q   <= '0;
         r_q     <= '0;
         ovf_q   <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         xa_q    <= xa_d;
         yb_q    <= yb_d;
         carry_q <= carry_d;
         sum_q   <= sum_d;
         r_q     <= r_d;
         ovf_q   <= ovf_d;
         done_q  <= (state_q == S_DONE);
      end
   end

   assign bus.busy = (state_q == S_RUN) || (state_q == S_DONE);
   assign bus.done = done_q;
   assign bus.r    = r_q;
   assign bus.ovf  = ovf_q;
   assign state_o  = state_q;
endmodule

// File: tb/tb_multicycle_adder.sv
// Bench for multicycle_adder: a CHUNK=2 and a CHUNK=8 instance share stimulus
// and are each followed by a transaction-level arithmetic model.
module tb_multicycle_adder;
   logic clk = 1'b0;
   logic rst;
   logic start, op_sub, cin;
   logic [7:0] x, y;
   logic [1:0] state_a, state_b;

   int n_cmp = 0;
   int n_err = 0;
   bit chk_en = 0;

   always #5 clk = ~clk;

   multicycle_adder_if #(.WIDTH(8)) if_a ();
   multicycle_adder_if #(.WIDTH(8)) if_b ();

   assign if_a.start  = start;
   assign if_a.op_sub = op_sub;
   assign if_a.cin    = cin;
   assign if_a.x      = x;
   assign if_a.y      = y;
   assign if_b.start  = start;
   assign if_b.op_sub = op_sub;
   assign if_b.cin    = cin;
   assign if_b.x      = x;
   assign if_b.y      = y;

   multicycle_adder #(.WIDTH(8), .CHUNK(2)) dut_a (.clk(clk), .rst(rst), .bus(if_a), .state_o(state_a));
   multicycle_adder #(.WIDTH(8), .CHUNK(8)) dut_b (.clk(clk), .rst(rst), .bus(if_b), .state_o(state_b));

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Expected {ovf, r} from plain integer arithmetic.
   function automatic logic [9:0] ref_result(input logic sub, input logic c,
                                             input logic [7:0] a, input logic [7:0] b);
      int sa, sb, ss;
      logic [8:0] full;
      sa = int'($signed(a));
      sb = int'($signed(b));
      if (sub) begin
         full = {(a >= b), 8'(a - b)};
         ss   = sa - sb;
      end else begin
         full = 9'(int'(a) + int'(b) + int'(c));
         ss   = sa + sb + int'(c);
      end
      return {(ss > 127) || (ss < -128), full};
   endfunction

   // Model: an accepted op keeps the unit busy for NCHUNK+1 cycles, then done.
   int         nch[2] = '{4, 1};
   int         busy_left[2];
   bit         done_exp[2];
   logic [8:0] last_r[2];
   logic       last_ovf[2];
   logic [9:0] exp_q[2][$];

   always @(posedge clk) begin
      for (int d = 0; d < 2; d++) begin
         if (rst) begin
            busy_left[d] = 0;
            done_exp[d]  = 0;
            last_r[d]    = '0;
            last_ovf[d]  = 1'b0;
            exp_q[d].delete();
         end else begin
            done_exp[d] = 0;
            if (busy_left[d] > 0) begin
               busy_left[d]--;
               if (busy_left[d] == 0) begin
                  {last_ovf[d], last_r[d]} = exp_q[d].pop_front();
                  done_exp[d] = 1;
               end
            end else if (start) begin
               exp_q[d].push_back(ref_result(op_sub, cin, x, y));
               busy_left[d] = nch[d] + 1;
            end
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         check("busy_a", 32'(if_a.busy), 32'(busy_left[0] > 0));
         check("done_a", 32'(if_a.done), 32'(done_exp[0]));
         check("busy_b", 32'(if_b.busy), 32'(busy_left[1] > 0));
         check("done_b", 32'(if_b.done), 32'(done_exp[1]));
         if (busy_left[0] == 0) begin
            check("r_a", 32'(if_a.r), 32'(last_r[0]));
            check("ovf_a", 32'(if_a.ovf), 32'(last_ovf[0]));
         end
         if (busy_left[1] == 0) begin
            check("r_b", 32'(if_b.r), 32'(last_r[1]));
            check("ovf_b", 32'(if_b.ovf), 32'(last_ovf[1]));
         end
      end
   end

   task automatic do_op(input logic sub, input logic c, input logic [7:0] a, input logic [7:0] b,
                        output logic [8:0] r_got, output logic ovf_got,
                        output int lat_a, output int lat_b);
      @(negedge clk);
      op_sub = sub; cin = c; x = a; y = b; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      op_sub = 1'($urandom_range(0, 1)); cin = 1'($urandom_range(0, 1));
      x = 8'($urandom_range(0, 255)); y = 8'($urandom_range(0, 255));
      lat_a = -1; lat_b = -1; r_got = '0; ovf_got = 1'b0;
      for (int i = 1; i <= 20 && lat_a < 0; i++) begin
         @(negedge clk);
         if (if_b.done && lat_b < 0) lat_b = i;
         if (if_a.done) begin
            lat_a = i;
            r_got = if_a.r;
            ovf_got = if_a.ovf;
         end
      end
      check("done_seen", 32'(lat_a >= 0), 32'd1);
   endtask

   initial begin
      logic [8:0] rg;
      logic       og;
      int         la, lb, last_t, seen;
      rst = 1'b1; start = 1'b0; op_sub = 1'b0; cin = 1'b0; x = '0; y = '0;
      @(negedge clk);
      chk_en = 1;
      @(negedge clk);
      rst = 1'b0;
      check("rst_r", 32'(if_a.r), 32'h000);
      check("rst_ovf", 32'(if_a.ovf), 32'd0);
      check("rst_busy", 32'(if_a.busy), 32'd0);
      check("rst_done", 32'(if_a.done), 32'd0);
      check("rst_state", 32'(state_a), 32'd0);
      repeat (3) @(negedge clk);

      do_op(1'b0, 1'b1, 8'd200, 8'd100, rg, og, la, lb);
      check("add_r", 32'(rg), 32'h12D);
      check("add_ovf", 32'(og), 32'd0);
      check("lat_a", 32'(la), 32'd5);
      check("lat_b", 32'(lb), 32'd2);

      do_op(1'b1, 1'b0, 8'd5, 8'd7, rg, og, la, lb);
      check("sub57_r", 32'(rg), 32'h0FE);
      check("sub57_ovf", 32'(og), 32'd0);
      do_op(1'b1, 1'b1, 8'd7, 8'd5, rg, og, la, lb);
      check("sub75_r", 32'(rg), 32'h102);
      do_op(1'b0, 1'b0, 8'h7F, 8'h01, rg, og, la, lb);
      check("ovfp_r", 32'(rg), 32'h080);
      check("ovfp_ovf", 32'(og), 32'd1);
      do_op(1'b0, 1'b0, 8'h80, 8'h80, rg, og, la, lb);
      check("ovfn_r", 32'(rg), 32'h100);
      check("ovfn_ovf", 32'(og), 32'd1);

      // Restart attempt during RUN is ignored.
      @(negedge clk);
      op_sub = 1'b0; cin = 1'b0; x = 8'd3; y = 8'd4; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      x = 8'd9; y = 8'd9; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      la = -1;
      for (int i = 0; i < 10 && la < 0; i++) begin
         @(negedge clk);
         if (if_a.done) begin la = i; rg = if_a.r; end
      end
      check("ign_done", 32'(la >= 0), 32'd1);
      check("ign_r", 32'(rg), 32'd7);
      repeat (8) @(negedge clk);

      // Start held high: back-to-back ops with changing operands.
      last_t = -1; seen = 0;
      start = 1'b1;
      for (int i = 0; i < 30 && seen < 4; i++) begin
         @(negedge clk);
         if (if_a.done) begin
            if (last_t >= 0) check("spacing", 32'(i - last_t), 32'd6);
            last_t = i;
            seen++;
         end
         op_sub = 1'($urandom_range(0, 1)); cin = 1'($urandom_range(0, 1));
         x = 8'($urandom_range(0, 255)); y = 8'($urandom_range(0, 255));
      end
      check("held_seen", 32'(seen), 32'd4);
      start = 1'b0;
      repeat (10) @(negedge clk);

      // Reset in the second RUN cycle aborts the operation.
      op_sub = 1'b0; cin = 1'b0; x = 8'd50; y = 8'd60; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("abort_busy", 32'(if_a.busy), 32'd0);
      check("abort_r", 32'(if_a.r), 32'd0);
      check("abort_done", 32'(if_a.done), 32'd0);
      repeat (8) @(negedge clk);
      do_op(1'b0, 1'b0, 8'd1, 8'd1, rg, og, la, lb);
      check("post_r", 32'(rg), 32'd2);

      for (int n = 0; n < 30; n++) begin
         do_op(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), rg, og, la, lb);
         check("rand_lat", 32'(la), 32'd5);
      end
      repeat (3) @(negedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
